dial_switch_debounce: RTL and testbench

//  Conditions the 8 raw dial-switch pins before the switch-to-LED stage.
//  - Each bit gets a 2-flop synchronizer, then a per-bit debounce counter paced by a shared prescaler tick.
//  - Outputs a clean 8-bit switch word and a one-cycle change strobe.
//  - Drives the SWICH input of the LED stage directly.

---
 rtl/dial_switch_pkg.sv | 27 ++
 rtl/switch_debounce_bit.sv | 71 +++++++
 rtl/dial_switch_debounce.sv | 84 ++++++++
 tb/tb_dial_switch_debounce.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dial_switch_pkg.sv
// Purpose  : shared width, word type and default tuning for the dial-switch debounce slice.
// Latency  : n/a (types and constants only).
// Backpress: n/a.
// Ports    : none (package).
package dial_switch_pkg;

  localparam int SW_W = 8;

  typedef logic [SW_W-1:0] sw_word_t;

  // Defaults sized for a 50 MHz core clock: 1 ms tick, 10 ms acceptance window.
  localparam int       DEF_PRESCALE  = 50000;
  localparam int       DEF_DEB_CNT   = 10;
  localparam sw_word_t DEF_RESET_VAL = 8'hFF;

  // Width needed by a per-bit tick counter that must hold 0..deb_cnt.
  function automatic int cnt_width(input int deb_cnt);
    return $clog2(deb_cnt + 1);
  endfunction

  // Width of the prescaler counting 0..prescale-1. At least one bit, so that
  // prescale == 1 still gives a legal (constant-zero) counter.
  function automatic int pre_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Purpose  : one switch bit: 2-flop synchronizer, tick-paced agreement counter, stable flop.
// Latency  : 2 sync cycles plus DEB_CNT consecutive differing ticks before 'stable' follows.
// Backpress: none; free-running, consumes every sample.
// Ports    : CLK, RST (sync, active-high), tick (prescaler pulse), raw (async pin),
//            rst_val (idle level), stable (debounced bit), changed (combinational:
//            'stable' takes the synchronized value at the coming edge).
module switch_debounce_bit
  import dial_switch_pkg::*;
#(
  parameter int DEB_CNT = DEF_DEB_CNT
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic raw,
  input  logic rst_val,
  output logic stable,
  output logic changed
);

  localparam int             CW       = cnt_width(DEB_CNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Synchronizer. Preloading the idle level keeps a reset from being seen
  // as a fresh transition on the pin.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= rst_val;
      s2 <= rst_val;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any cycle where the synchronized bit agrees with 'stable' clears the
  // count, so a bounce back restarts the window from zero. The count only
  // advances on ticks, and the last tick of the window accepts the bit.
  always_comb begin
    cnt_nxt = cnt;
    changed = 1'b0;
    if (s2 == stable) begin
      cnt_nxt = '0;
    end else if (tick) begin
      if (cnt == CNT_LAST) begin
        changed = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      stable <= rst_val;
    end else begin
      cnt <= cnt_nxt;
      if (changed) begin
        stable <= s2;
      end
    end
  end

endmodule

// File: rtl/dial_switch_debounce.sv
// Purpose  : conditions the 8 raw dial-switch pins into a clean word for the LED stage SWICH input.
// Latency  : stable pin change to SW_DB in 2+(DEB_CNT-1)*PRESCALE+1 .. 2+DEB_CNT*PRESCALE cycles.
// Backpress: none; SW_CHG (and edge pulses) are single-cycle and must be consumed when seen.
// Ports    : CLK, RST (sync, active-high), SW_RAW[7:0] (async pins), SW_DB[7:0] (debounced),
//            SW_CHG (one-cycle pulse aligned with the SW_DB update),
//            SW_RISE[7:0] / SW_FALL[7:0] (per-bit accepted 0->1 / 1->0 pulses, only with SW_EDGE_EN).
// Config   : define SW_EDGE_EN to add the SW_RISE/SW_FALL ports and their registers.
module dial_switch_debounce
  import dial_switch_pkg::*;
#(
  parameter int       PRESCALE  = DEF_PRESCALE,
  parameter int       DEB_CNT   = DEF_DEB_CNT,
  parameter sw_word_t RESET_VAL = DEF_RESET_VAL
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [SW_W-1:0] SW_RAW,
  output logic [SW_W-1:0] SW_DB,
`ifdef SW_EDGE_EN
  output logic [SW_W-1:0] SW_RISE,
  output logic [SW_W-1:0] SW_FALL,
`endif
  output logic            SW_CHG
);

  localparam int            PW     = pre_width(PRESCALE);
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]   pcnt;
  logic            tick;
  logic [SW_W-1:0] bit_chg;

  // Shared prescaler; every bit samples the same tick so their windows line up.
  assign tick = (pcnt == P_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  for (genvar i = 0; i < SW_W; i++) begin : gen_bit
    switch_debounce_bit #(
      .DEB_CNT (DEB_CNT)
    ) u_bit (
      .CLK     (CLK),
      .RST     (RST),
      .tick    (tick),
      .raw     (SW_RAW[i]),
      .rst_val (RESET_VAL[i]),
      .stable  (SW_DB[i]),
      .changed (bit_chg[i])
    );
  end

  // bit_chg is the decision for the coming edge, so registering it here puts
  // the pulses in the same cycle as the new SW_DB value. Several bits
  // accepted together collapse into one SW_CHG pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SW_CHG <= 1'b0;
    end else begin
      SW_CHG <= |bit_chg;
    end
  end

`ifdef SW_EDGE_EN
  // SW_DB still holds the old level here, which gives the edge direction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      SW_RISE <= '0;
      SW_FALL <= '0;
    end else begin
      SW_RISE <= bit_chg & ~SW_DB;
      SW_FALL <= bit_chg &  SW_DB;
    end
  end
`endif

endmodule

// File: tb/tb_dial_switch_debounce.sv
// Purpose  : self-checking bench for dial_switch_debounce (PRESCALE=4, DEB_CNT=3, RESET_VAL=8'hFF).
// Latency  : n/a.
// Backpress: n/a.
// Ports    : none; define SW_EDGE_EN to also check SW_RISE/SW_FALL.
module tb_dial_switch_debounce;

  localparam int         P  = 4;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hFF;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] SW_RAW;
  logic [7:0] SW_DB;
  logic       SW_CHG;
`ifdef SW_EDGE_EN
  logic [7:0] SW_RISE;
  logic [7:0] SW_FALL;
`endif

  int errors = 0;
  int checks = 0;

  dial_switch_debounce #(
    .PRESCALE  (P),
    .DEB_CNT   (D),
    .RESET_VAL (RV)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .SW_RAW  (SW_RAW),
    .SW_DB   (SW_DB),
`ifdef SW_EDGE_EN
    .SW_RISE (SW_RISE),
    .SW_FALL (SW_FALL),
`endif
    .SW_CHG  (SW_CHG)
  );

  always #5 CLK = ~CLK;

  // Reference: the pin reaches the decision point two edges late; edges since
  // reset define tick positions; each bit counts ticks spent disagreeing and
  // is accepted on the D-th, any agreeing cycle clearing the tally.
  logic [7:0] m_pipe [2];
  logic [7:0] m_db   = RV;
  logic       m_chg  = 1'b0;
  logic [7:0] m_rise = '0;
  logic [7:0] m_fall = '0;
  int         m_edges = 0;
  int         m_tally [8];

  task automatic model_edge();
    logic [7:0] acc;
    bit         is_tick;
    acc = '0;
    if (RST) begin
      m_pipe[0] = RV;
      m_pipe[1] = RV;
      m_db      = RV;
      m_edges   = 0;
      for (int i = 0; i < 8; i++) m_tally[i] = 0;
      m_chg  = 1'b0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      is_tick = ((m_edges % P) == (P - 1));
      for (int i = 0; i < 8; i++) begin
        if (m_pipe[1][i] == m_db[i]) m_tally[i] = 0;
        else if (is_tick) begin
          m_tally[i] = m_tally[i] + 1;
          if (m_tally[i] == D) begin
            acc[i]     = 1'b1;
            m_tally[i] = 0;
          end
        end
      end
      m_rise    = acc & ~m_db;
      m_fall    = acc & m_db;
      m_db      = m_db ^ acc;
      m_chg     = |acc;
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = SW_RAW;
      m_edges   = m_edges + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d..%0d", name, $time, act, lo, hi);
    end
  endtask

  // One clock: advance the reference on the edge, compare 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("model_db", SW_DB, m_db);
    chk("model_chg", SW_CHG, m_chg);
`ifdef SW_EDGE_EN
    chk("model_rise", SW_RISE, m_rise);
    chk("model_fall", SW_FALL, m_fall);
`endif
  endtask

  task automatic do_reset(input int n, input logic [7:0] raw);
    RST    = 1'b1;
    SW_RAW = raw;
    repeat (n) step();
    RST = 1'b0;
  endtask

  // Runs 'bound' cycles; lat = first cycle SW_DB equals target (-1 if never).
  task automatic wait_db(input logic [7:0] target, input int bound, output int lat, output int chg_cnt);
    lat     = -1;
    chg_cnt = 0;
    for (int k = 1; k <= bound; k++) begin
      step();
      if (SW_CHG === 1'b1) chg_cnt++;
      if (lat < 0 && SW_DB === target) lat = k;
    end
  endtask

  typedef struct {
    logic [7:0] raw;
    int         hold;
    logic [7:0] exp_db;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int         lat;
    int         cc;
    int         bad;
    int         seen;
    logic [7:0] first_db;
    logic [7:0] first_rise;
    logic [7:0] first_fall;

    tbl[0] = '{raw: 8'hFF, hold: 16, exp_db: 8'hFF};
    tbl[1] = '{raw: 8'hFE, hold: 16, exp_db: 8'hFE};
    tbl[2] = '{raw: 8'hFC, hold: 16, exp_db: 8'hFC};
    tbl[3] = '{raw: 8'hF0, hold: 4,  exp_db: 8'hFC};
    tbl[4] = '{raw: 8'hF0, hold: 16, exp_db: 8'hF0};
    tbl[5] = '{raw: 8'hFF, hold: 3,  exp_db: 8'hF0};
    tbl[6] = '{raw: 8'hFF, hold: 16, exp_db: 8'hFF};
    tbl[7] = '{raw: 8'hA5, hold: 16, exp_db: 8'hA5};

    m_pipe[0] = RV;
    m_pipe[1] = RV;
    for (int i = 0; i < 8; i++) m_tally[i] = 0;

    // 1. Reset held with pins low: idle level during and after reset.
    RST    = 1'b1;
    SW_RAW = 8'h00;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset_db", SW_DB, 8'hFF);
      chk("reset_chg", SW_CHG, 1'b0);
    end
    RST = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (SW_CHG !== 1'b0 || SW_DB !== 8'hFF) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    wait_db(8'h00, 10, lat, cc);
    chk("post_reset_accept", SW_DB, 8'h00);

    // 2. Clean single-bit change.
    do_reset(2, 8'hFF);
    SW_RAW = 8'hFE;
    wait_db(8'hFE, 20, lat, cc);
    chk_range("clean_latency", lat, 9, 14);
    chk("clean_db", SW_DB, 8'hFE);
    chk("clean_chg_pulses", cc, 1);

    // 3. Bit 3 bouncing every 5 cycles never gets accepted, then settles.
    do_reset(2, 8'hFF);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      SW_RAW = (((c / 5) % 2) == 0) ? 8'hF7 : 8'hFF;
      step();
      if (SW_DB[3] !== 1'b1) bad++;
    end
    chk("bounce_no_change", bad, 0);
    SW_RAW = 8'hF7;
    wait_db(8'hF7, 20, lat, cc);
    chk_range("bounce_settle_latency", lat, 1, 14);

    // 4. Short glitch on bit 7.
    do_reset(2, 8'hFF);
    bad  = 0;
    seen = 0;
    SW_RAW = 8'h7F;
    for (int c = 0; c < 26; c++) begin
      if (c == 6) SW_RAW = 8'hFF;
      step();
      if (SW_DB !== 8'hFF) bad++;
      if (SW_CHG !== 1'b0) seen++;
    end
    chk("glitch_db", bad, 0);
    chk("glitch_chg", seen, 0);

    // 5. All bits change together: one update edge, one pulse.
    do_reset(2, 8'hFF);
    SW_RAW     = 8'h00;
    cc         = 0;
    seen       = 0;
    first_db   = 8'hFF;
    first_rise = 8'h00;
    first_fall = 8'h00;
    for (int c = 0; c < 20; c++) begin
      step();
      if (SW_CHG === 1'b1) cc++;
      if (seen == 0 && SW_DB !== 8'hFF) begin
        seen     = 1;
        first_db = SW_DB;
`ifdef SW_EDGE_EN
        first_rise = SW_RISE;
        first_fall = SW_FALL;
`endif
      end
    end
    chk("multi_first_db", first_db, 8'h00);
    chk("multi_chg_pulses", cc, 1);
`ifdef SW_EDGE_EN
    chk("multi_fall", first_fall, 8'hFF);
    chk("multi_rise", first_rise, 8'h00);
`endif

    // 6. Reset mid-debounce discards partial progress.
    do_reset(2, 8'hFF);
    SW_RAW = 8'hFE;
    repeat (4) step();
    RST = 1'b1;
    repeat (2) step();
    chk("midrst_db", SW_DB, 8'hFF);
    RST = 1'b0;
    wait_db(8'hFE, 20, lat, cc);
    chk_range("midrst_latency", lat, 9, 14);

    // Table of held patterns.
    do_reset(2, 8'hFF);
    for (int v = 0; v < 8; v++) begin
      SW_RAW = tbl[v].raw;
      repeat (tbl[v].hold) step();
      chk($sformatf("table_%0d_db", v), SW_DB, tbl[v].exp_db);
    end

    // Random segments against the reference, with occasional resets.
    do_reset(2, 8'hFF);
    for (int s = 0; s < 120; s++) begin
      if ($urandom_range(0, 14) == 0) begin
        do_reset($urandom_range(1, 3), 8'($urandom));
      end else begin
        if ($urandom_range(0, 1) == 0) SW_RAW = 8'($urandom);
        else SW_RAW = SW_RAW ^ (8'h01 << $urandom_range(0, 7));
        repeat ($urandom_range(1, 18)) step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
